// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Streaming RV32IM instruction encoder. Takes an operation
//               index plus register/immediate fields over valid/ready and
//               emits the 32-bit instruction word through a 2-entry FIFO.
//               Illegal requests emit a nop with err set.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [31:0] c_nop       = 32'h0000_0013;
    localparam logic [31:0] c_ecall     = 32'h0000_0073;
    localparam logic [31:0] c_ebreak    = 32'h0010_0073;
    localparam logic [6:0]  c_opc_op    = 7'b0110011;
    localparam logic [6:0]  c_opc_imm   = 7'b0010011;
    localparam logic [6:0]  c_opc_load  = 7'b0000011;
    localparam logic [6:0]  c_opc_store = 7'b0100011;
    localparam logic [6:0]  c_opc_br    = 7'b1100011;
    localparam logic [6:0]  c_opc_jal   = 7'b1101111;
    localparam logic [6:0]  c_opc_jalr  = 7'b1100111;
    localparam logic [6:0]  c_opc_lui   = 7'b0110111;
    localparam logic [6:0]  c_opc_auipc = 7'b0010111;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // FIFO storage: slot0 is always the head, slot1 the entry behind it.
    logic [32:0]      slot0_q, slot0_d;
    logic [32:0]      slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_i12_ok;
    logic        w_shamt_ok;
    logic        w_b_ok;
    logic        w_j_ok;
    logic        w_u_ok;
    logic [31:0] w_enc;
    logic        w_bad;
    logic [32:0] w_entry;

    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign instr       = slot0_q[31:0];
    assign err         = slot0_q[32];
    assign instr_count = icnt_q;
    assign err_count   = ecnt_q;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Signed range checks: upper bits must be a pure sign extension.
    assign w_i12_ok   = (&imm[31:11]) || !(|imm[31:11]);
    assign w_shamt_ok = !(|imm[31:5]);
    assign w_b_ok     = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
    assign w_j_ok     = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
    assign w_u_ok     = !(|imm[31:20]);

    // func7: 0x20 for sub/sra/srai, 0x01 for the M extension, else zero.
    assign w_f7 = (op == 6'd1 || op == 6'd7 || op == 6'd16) ? 7'h20 :
                  (op >= 6'd39 && op <= 6'd46)             ? 7'h01 : 7'h00;

    // func3 lookup by operation index.
    always_comb begin
        w_f3 = 3'd0;
        case (op)
            6'd5,  6'd14, 6'd20, 6'd25, 6'd28, 6'd40:        w_f3 = 3'd1;
            6'd8,  6'd17, 6'd21, 6'd26, 6'd41:               w_f3 = 3'd2;
            6'd9,  6'd18, 6'd42:                             w_f3 = 3'd3;
            6'd2,  6'd11, 6'd22, 6'd29, 6'd43:               w_f3 = 3'd4;
            6'd6,  6'd7,  6'd15, 6'd16, 6'd23, 6'd30, 6'd44: w_f3 = 3'd5;
            6'd3,  6'd12, 6'd31, 6'd45:                      w_f3 = 3'd6;
            6'd4,  6'd13, 6'd32, 6'd46:                      w_f3 = 3'd7;
            default:                                         w_f3 = 3'd0;
        endcase
    end

    // Assemble the instruction word; illegal requests collapse to a nop.
    always_comb begin
        w_enc = c_nop;
        w_bad = 1'b0;
        case (op) inside
            [6'd0:6'd9], [6'd39:6'd46]:
                w_enc = {w_f7, rs2, rs1, w_f3, rd, c_opc_op};
            6'd10, 6'd11, 6'd12, 6'd13, 6'd17, 6'd18: begin
                w_bad = !w_i12_ok;
                w_enc = {imm[11:0], rs1, w_f3, rd, c_opc_imm};
            end
            6'd14, 6'd15, 6'd16: begin
                w_bad = !w_shamt_ok;
                w_enc = {w_f7, imm[4:0], rs1, w_f3, rd, c_opc_imm};
            end
            [6'd19:6'd23]: begin
                w_bad = !w_i12_ok;
                w_enc = {imm[11:0], rs1, w_f3, rd, c_opc_load};
            end
            [6'd24:6'd26]: begin
                w_bad = !w_i12_ok;
                w_enc = {imm[11:5], rs2, rs1, w_f3, imm[4:0], c_opc_store};
            end
            [6'd27:6'd32]: begin
                w_bad = !w_b_ok;
                w_enc = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], c_opc_br};
            end
            6'd33: begin
                w_bad = !w_j_ok;
                w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, c_opc_jal};
            end
            6'd34: begin
                w_bad = !w_i12_ok;
                w_enc = {imm[11:0], rs1, 3'd0, rd, c_opc_jalr};
            end
            6'd35: begin
                w_bad = !w_u_ok;
                w_enc = {imm[19:0], rd, c_opc_lui};
            end
            6'd36: begin
                w_bad = !w_u_ok;
                w_enc = {imm[19:0], rd, c_opc_auipc};
            end
            6'd37: w_enc = c_ecall;
            6'd38: w_enc = c_ebreak;
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_enc = c_nop;
        end
    end

    assign w_entry = {w_bad, w_enc};

    // FIFO next state: push fills the first free slot, pop shifts slot1 forward.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = w_entry;
                end else begin
                    slot1_d = w_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    slot0_d = slot1_q;
                end
                count_d = count_q - 2'd1;
            end
            // Push with pop only happens at count 1: the new word becomes head.
            2'b11: slot0_d = w_entry;
            default: ;
        endcase
    end

    // Saturating pop counters.
    always_comb begin
        icnt_d = icnt_q;
        ecnt_d = ecnt_q;
        if (w_pop && icnt_q != c_cnt_max) begin
            icnt_d = icnt_q + c_cnt_one;
        end
        if (w_pop && slot0_q[32] && ecnt_q != c_cnt_max) begin
            ecnt_d = ecnt_q + c_cnt_one;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            icnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            icnt_q  <= icnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

endmodule
`default_nettype wire
